// File: rtl/sram_arb_2p.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_2p
// Description : Two-requester round-robin arbiter in front of a single-port
//               SRAM, with optional zero-fill of the whole array after reset.
// Revision    : 1.0  initial release
// ============================================================================
module sram_arb_2p #(
    parameter int AW             = 16,
    parameter int DW             = 23,
    parameter int DEPTH          = 65536,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_wr,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_wr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          cs_en,
    output logic          wr_en,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wr_data,
    input  logic [DW-1:0] rd_data,
    output logic          init_done
);

    localparam logic [0:0]    C_ST_INIT     = 1'b0;
    localparam logic [0:0]    C_ST_ACTIVE   = 1'b1;
    localparam logic [0:0]    C_RESET_STATE = CLEAR_ON_RESET ? C_ST_INIT : C_ST_ACTIVE;
    localparam logic [AW-1:0] C_LAST_ADDR   = AW'(DEPTH - 1);

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [AW-1:0] r_init_cnt;
    logic          r_prio;          // 1: r1 wins the next tie
    logic          w_init_drive;
    logic          w_active;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_hs;
    logic          w_sel;
    logic          w_wr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          r_cs_en;
    logic          r_wr_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_rd_pend;
    logic          r_rd_id;
    logic          r_rvalid0;
    logic          r_rvalid1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_init_drive = 1'b0;
        w_active     = 1'b0;
        case (r_state)
            C_ST_INIT: begin
                w_init_drive = rst_n;
                if (rst_n && (r_init_cnt == C_LAST_ADDR)) begin
                    w_state_next = C_ST_ACTIVE;
                end
            end
            default: begin
                w_active = rst_n;
            end
        endcase
    end

    assign w_gnt0  = w_active & r0_valid & (~r1_valid | ~r_prio);
    assign w_gnt1  = w_active & r1_valid & (~r0_valid |  r_prio);
    assign w_hs    = w_gnt0 | w_gnt1;
    assign w_sel   = w_gnt1;
    assign w_wr    = w_sel ? r1_wr    : r0_wr;
    assign w_addr  = w_sel ? r1_addr  : r0_addr;
    assign w_wdata = w_sel ? r1_wdata : r0_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_init_cnt <= '0;
            r_prio     <= 1'b0;
            r_cs_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_id    <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_cs_en <= w_hs;
            if (w_hs) begin
                r_wr_en   <= w_wr;
                r_addr    <= w_addr;
                r_wr_data <= w_wdata;
                r_prio    <= ~w_sel;
            end
            // Read data returns one cycle after the SRAM access cycle.
            r_rd_pend <= w_hs & ~w_wr;
            r_rd_id   <= w_sel;
            r_rvalid0 <= r_rd_pend & ~r_rd_id;
            r_rvalid1 <= r_rd_pend &  r_rd_id;
            if (w_init_drive) begin
                r_init_cnt <= (r_init_cnt == C_LAST_ADDR) ? '0 : r_init_cnt + 1'b1;
            end
        end
    end

    // Zero-fill drives the SRAM straight from the counter so it starts at once.
    assign cs_en     = w_init_drive | r_cs_en;
    assign wr_en     = w_init_drive | r_wr_en;
    assign addr      = w_init_drive ? r_init_cnt : r_addr;
    assign wr_data   = w_init_drive ? '0 : r_wr_data;
    assign init_done = w_active;
    assign r0_ready  = w_gnt0;
    assign r1_ready  = w_gnt1;
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign r0_rdata  = rd_data;
    assign r1_rdata  = rd_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_arb_2p.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arb_2p
// Description : Self-checking bench for sram_arb_2p (arbitration, read return,
//               reset behaviour and full zero-fill).
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arb_2p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // ---------------- instance C: no zero-fill, randomized traffic ----------
    logic        rst_n_c;
    logic        v [2];
    logic        w [2];
    logic [15:0] a [2];
    logic [22:0] d [2];
    logic        c_r0_ready, c_r1_ready, c_r0_rvalid, c_r1_rvalid;
    logic [22:0] c_r0_rdata, c_r1_rdata;
    logic        c_cs_en, c_wr_en, c_init_done;
    logic [15:0] c_addr;
    logic [22:0] c_wr_data;
    logic [22:0] c_rd_data = '0;

    sram_arb_2p #(.CLEAR_ON_RESET(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n_c),
        .r0_valid(v[0]), .r0_ready(c_r0_ready), .r0_wr(w[0]), .r0_addr(a[0]),
        .r0_wdata(d[0]), .r0_rvalid(c_r0_rvalid), .r0_rdata(c_r0_rdata),
        .r1_valid(v[1]), .r1_ready(c_r1_ready), .r1_wr(w[1]), .r1_addr(a[1]),
        .r1_wdata(d[1]), .r1_rvalid(c_r1_rvalid), .r1_rdata(c_r1_rdata),
        .cs_en(c_cs_en), .wr_en(c_wr_en), .addr(c_addr), .wr_data(c_wr_data),
        .rd_data(c_rd_data), .init_done(c_init_done)
    );

    // SRAM environment: registered read, one cycle latency, zero content.
    logic [22:0] sram [int];
    always @(posedge clk) begin
        if (c_cs_en) begin
            if (c_wr_en) sram[int'(c_addr)] = c_wr_data;
            else c_rd_data <= sram.exists(int'(c_addr)) ? sram[int'(c_addr)] : 23'd0;
        end
    end

    // ---------------- instances A and B: zero-fill enabled -----------------
    logic        rst_a, rst_b, va;
    logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_cs, a_wr, a_done;
    logic [22:0] a_rd0, a_rd1, a_wd;
    logic [15:0] a_addr;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_cs, b_wr, b_done;
    logic [22:0] b_rd0, b_rd1, b_wd;
    logic [15:0] b_addr;

    sram_arb_2p u_dut_a (
        .clk(clk), .rst_n(rst_a),
        .r0_valid(va), .r0_ready(a_rdy0), .r0_wr(1'b1), .r0_addr(16'h00AB),
        .r0_wdata(23'h5A5A5), .r0_rvalid(a_rv0), .r0_rdata(a_rd0),
        .r1_valid(va), .r1_ready(a_rdy1), .r1_wr(1'b0), .r1_addr(16'h0011),
        .r1_wdata(23'h0), .r1_rvalid(a_rv1), .r1_rdata(a_rd1),
        .cs_en(a_cs), .wr_en(a_wr), .addr(a_addr), .wr_data(a_wd),
        .rd_data(23'h0), .init_done(a_done)
    );

    sram_arb_2p u_dut_b (
        .clk(clk), .rst_n(rst_b),
        .r0_valid(1'b0), .r0_ready(b_rdy0), .r0_wr(1'b0), .r0_addr(16'h0),
        .r0_wdata(23'h0), .r0_rvalid(b_rv0), .r0_rdata(b_rd0),
        .r1_valid(1'b0), .r1_ready(b_rdy1), .r1_wr(1'b0), .r1_addr(16'h0),
        .r1_wdata(23'h0), .r1_rvalid(b_rv1), .r1_rdata(b_rd1),
        .cs_en(b_cs), .wr_en(b_wr), .addr(b_addr), .wr_data(b_wd),
        .rd_data(23'h0), .init_done(b_done)
    );

    // ---------------- reference model state --------------------------------
    typedef struct {
        int          id;
        logic [22:0] data;
        int          due;
    } rd_t;

    rd_t         rdq [$];
    logic [22:0] mem_m [int];
    int          cyc = 0;
    int          last_srv = 1;
    logic        e_cs = 1'b0, e_wr = 1'b0;
    logic [15:0] e_addr = '0;
    logic [22:0] e_wd = '0;
    logic [1:0]  rdy_obs, rv_obs, hs_last;
    logic [22:0] rd1_obs;
    logic        cs_obs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic newcmd(input int n);
        w[n] = 1'($urandom_range(0, 1));
        a[n] = 16'($urandom_range(0, 15));
        d[n] = 23'($urandom);
    endtask

    // One clock of instance C: check outputs against the model, then advance it.
    task automatic tick();
        logic [1:0] eg;
        logic       ev0, ev1;
        int         id;
        @(negedge clk);
        rdy_obs = {c_r1_ready, c_r0_ready};
        rv_obs  = {c_r1_rvalid, c_r0_rvalid};
        rd1_obs = c_r1_rdata;
        cs_obs  = c_cs_en;
        eg = 2'b00;
        if (rst_n_c) begin
            if (v[0] && v[1]) eg = (last_srv == 1) ? 2'b01 : 2'b10;
            else              eg = {v[1], v[0]};
        end
        chk("r0_ready", c_r0_ready, eg[0]);
        chk("r1_ready", c_r1_ready, eg[1]);
        chk("init_done", c_init_done, rst_n_c);
        chk("sram_cmd", {c_cs_en, c_wr_en, c_addr, c_wr_data}, {e_cs, e_wr, e_addr, e_wd});
        ev0 = (rdq.size() > 0) && (rdq[0].due == cyc) && (rdq[0].id == 0);
        ev1 = (rdq.size() > 0) && (rdq[0].due == cyc) && (rdq[0].id == 1);
        chk("rvalid", rv_obs, {ev1, ev0});
        if (ev0 || ev1) begin
            chk("rdata", ev0 ? c_r0_rdata : c_r1_rdata, rdq[0].data);
            void'(rdq.pop_front());
        end
        chk("rdata_pass", {c_r1_rdata, c_r0_rdata}, {c_rd_data, c_rd_data});
        hs_last = eg;
        if (!rst_n_c) begin
            e_cs = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
            rdq.delete();
            last_srv = 1;
        end else if (eg != 2'b00) begin
            id = eg[1] ? 1 : 0;
            e_cs = 1'b1; e_wr = w[id]; e_addr = a[id]; e_wd = d[id];
            last_srv = id;
            if (w[id]) mem_m[int'(a[id])] = d[id];
            else rdq.push_back('{id: id,
                                 data: mem_m.exists(int'(a[id])) ? mem_m[int'(a[id])] : 23'd0,
                                 due: cyc + 2});
        end else begin
            e_cs = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    logic [15:0] eb;

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        newcmd(0); newcmd(1);
        rst_n_c = 1'b0; rst_a = 1'b0; rst_b = 1'b0; va = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("a_reset", {a_cs, a_done, a_rdy0, a_rdy1, a_addr}, 20'h0);
        @(posedge clk); #1;

        // Requests during reset must not be accepted.
        v[0] = 1'b1; v[1] = 1'b1;
        tick(); tick();
        v[0] = 1'b0; v[1] = 1'b0; rst_n_c = 1'b1;
        tick();

        // Write then read-back of the same word from the other requester.
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 16'h1234; d[0] = 23'h7FFFFF;
        tick(); chk("wr_grant", rdy_obs, 2'b01);
        v[0] = 1'b0; v[1] = 1'b1; w[1] = 1'b0; a[1] = 16'h1234;
        tick(); chk("rd_grant", rdy_obs, 2'b10);
        v[1] = 1'b0;
        tick(); chk("rv_t1", rv_obs, 2'b00);
        tick(); chk("rv_t2", rv_obs, 2'b10); chk("rd_t2", rd1_obs, 23'h7FFFFF);
        tick(); chk("rv_t3", rv_obs, 2'b00);

        // Continuous contention alternates grants.
        v[0] = 1'b1; v[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_grant", rdy_obs, (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i > 0) chk("rr_cs", cs_obs, 1'b1);
            for (int n = 0; n < 2; n++) if (hs_last[n]) newcmd(n);
        end
        v[0] = 1'b0; v[1] = 1'b0;
        tick(); chk("rr_cs_last", cs_obs, 1'b1);

        // r1 alone four times, then r0 wins the tie.
        v[1] = 1'b1; newcmd(1);
        for (int i = 0; i < 4; i++) begin
            tick(); chk("solo_r1", rdy_obs, 2'b10);
            newcmd(1);
        end
        v[0] = 1'b1; newcmd(0);
        tick(); chk("tie_after_r1", rdy_obs, 2'b01);
        v[0] = 1'b0; v[1] = 1'b0;
        repeat (3) tick();

        // Read in flight dropped by reset; r0 wins the first tie afterwards.
        v[0] = 1'b1; w[0] = 1'b0; a[0] = 16'h0007;
        tick();
        v[0] = 1'b0; rst_n_c = 1'b0; v[1] = 1'b1; newcmd(1);
        tick(); chk("rdy_in_rst", rdy_obs, 2'b00);
        rst_n_c = 1'b1; v[1] = 1'b0;
        tick(); chk("rv_dropped", rv_obs, 2'b00);
        tick(); chk("rv_dropped2", rv_obs, 2'b00);
        v[0] = 1'b1; v[1] = 1'b1; newcmd(0); newcmd(1);
        tick(); chk("tie_after_rst", rdy_obs, 2'b01);
        v[0] = 1'b0; v[1] = 1'b0;
        tick();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (hs_last[n] || !v[n]) begin
                    v[n] = ($urandom_range(0, 3) != 0);
                    newcmd(n);
                end
            end
            rst_n_c = ($urandom_range(0, 299) != 0);
            tick();
        end
        v[0] = 1'b0; v[1] = 1'b0; rst_n_c = 1'b1;
        repeat (3) tick();

        // Zero-fill: A runs the full fill, B is reset at address 0x8000.
        rst_a = 1'b1; rst_b = 1'b1; eb = '0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            chk("fill", {a_cs, a_wr, a_wd, a_addr, a_done, a_rdy0, a_rdy1},
                {1'b1, 1'b1, 23'd0, 16'(i), 3'b000});
            if (rst_b) chk("fill_b", {b_cs, b_wr, b_done, b_addr}, {3'b110, eb});
            else       chk("fill_b_rst", {b_cs, b_done, b_rdy0}, 3'b000);
            @(posedge clk); #1;
            eb = rst_b ? eb + 16'd1 : 16'd0;
            rst_b = (i != 32'h8000);
        end
        @(negedge clk);
        chk("init_end", {a_done, a_cs, a_rdy0, a_rdy1}, 4'b1010);
        @(posedge clk); #1;
        va = 1'b0;
        @(negedge clk);
        chk("post_init_hs", {a_cs, a_wr, a_addr, a_wd, a_done}, {2'b11, 16'h00AB, 23'h5A5A5, 1'b1});
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle", {a_cs, a_done, a_addr}, {2'b01, 16'h00AB});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
